// File: rtl/mem_req_initiator_pkg.sv
// Shared types for the memory request initiator: FSM state encoding and
// the captured operation kind.
package mem_req_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

endpackage

// File: rtl/mem_req_initiator_if.sv
// Client request/response channel plus single-port memory command bus.
// master = the initiator, slave = client and memory side.
interface mem_req_initiator_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_write;
   logic                  rsp_error;

   logic                  mem_wr_en;
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wr_data;
   logic [DATA_WIDTH-1:0] mem_rd_data;
   logic                  mem_ready;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
             mem_rd_data, mem_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_error,
             mem_wr_en, mem_rd_en, mem_addr, mem_wr_data
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
             mem_rd_data, mem_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_error,
             mem_wr_en, mem_rd_en, mem_addr, mem_wr_data
   );
endinterface

// File: rtl/mem_req_initiator_wait_timer.sv
// WAIT-state timer: saturating down-counter loaded on clear, with
// terminal-count compares for the latency gate and the timeout.
module mem_req_wait_timer #(
   parameter int RSP_LATENCY    = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic lat_met,
   output logic timed_out
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   // Loading TIMEOUT-1 makes the equivalent up-count read 1 in the first WAIT cycle.
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] LAT_TC   = CW'(TIMEOUT_CYCLES - RSP_LATENCY);

   logic [CW-1:0] rem_q, rem_d;

   always_comb begin
      rem_d = rem_q;
      if (clear) begin
         rem_d = LOAD_VAL;
      end else if (enable && (rem_q != '0)) begin
         rem_d = rem_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign lat_met   = (rem_q <= LAT_TC);
   assign timed_out = (rem_q == '0);

endmodule

// File: rtl/mem_req_initiator.sv
// Single-outstanding memory request initiator: accepts a client request,
// pulses the memory command, waits for completion and returns a response.
//
//   state | meaning
//   IDLE  | req_ready high, waiting for a client request
//   ISSUE | one-cycle mem_wr_en / mem_rd_en pulse
//   WAIT  | latency gate, then mem_ready or timeout
//   RESP  | rsp_valid held until rsp_ready
module mem_req_initiator
   import mem_req_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int RSP_LATENCY    = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   mem_req_initiator_if.master bus
);
   state_e                state_q, state_d;
   op_e                   op_q, op_d;
   logic                  req_ready_q, req_ready_d;
   logic                  mem_wr_en_q, mem_wr_en_d;
   logic                  mem_rd_en_q, mem_rd_en_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_write_q, rsp_write_d;
   logic                  rsp_error_q, rsp_error_d;

   logic tmr_clear, tmr_enable, lat_met, timed_out;

   assign tmr_clear  = (state_q == ISSUE);
   assign tmr_enable = (state_q == WAIT);

   mem_req_wait_timer #(
      .RSP_LATENCY    (RSP_LATENCY),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (tmr_clear),
      .enable    (tmr_enable),
      .lat_met   (lat_met),
      .timed_out (timed_out)
   );

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      req_ready_d   = req_ready_q;
      mem_wr_en_d   = 1'b0;
      mem_rd_en_d   = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_wr_data_d = mem_wr_data_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_write_d   = rsp_write_q;
      rsp_error_d   = rsp_error_q;

      unique case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            // Handshake only counts once req_ready is visible to the client.
            if (req_ready_q && bus.req_valid) begin
               op_d          = bus.req_write ? OP_WRITE : OP_READ;
               mem_addr_d    = bus.req_addr;
               mem_wr_data_d = bus.req_wdata;
               mem_wr_en_d   = bus.req_write;
               mem_rd_en_d   = !bus.req_write;
               req_ready_d   = 1'b0;
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (lat_met && bus.mem_ready) begin
               rsp_rdata_d = (op_q == OP_READ) ? bus.mem_rd_data : '0;
               rsp_error_d = 1'b0;
               rsp_write_d = (op_q == OP_WRITE);
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (timed_out) begin
               rsp_rdata_d = '0;
               rsp_error_d = 1'b1;
               rsp_write_d = (op_q == OP_WRITE);
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         op_q          <= OP_READ;
         req_ready_q   <= 1'b0;
         mem_wr_en_q   <= 1'b0;
         mem_rd_en_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wr_data_q <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_write_q   <= 1'b0;
         rsp_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         req_ready_q   <= req_ready_d;
         mem_wr_en_q   <= mem_wr_en_d;
         mem_rd_en_q   <= mem_rd_en_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_data_q <= mem_wr_data_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_write_q   <= rsp_write_d;
         rsp_error_q   <= rsp_error_d;
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.mem_wr_en   = mem_wr_en_q;
   assign bus.mem_rd_en   = mem_rd_en_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wr_data = mem_wr_data_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_write   = rsp_write_q;
   assign bus.rsp_error   = rsp_error_q;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator: vector table of single transactions
// against a small memory responder model, plus reset and back-to-back sequences.
module tb_mem_req_initiator;

   logic clk;
   logic rst_n;

   mem_req_initiator_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();

   mem_req_initiator #(
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (10),
      .RSP_LATENCY    (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [95:0] outs();
      return 96'({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_write, bus.rsp_error,
                  bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wr_data});
   endfunction

   // Responder: mode 0 = mem_ready pulse 2 cycles after the command,
   // mode 1 = mem_ready stuck high, mode 2 = never ready. Read data is
   // only correct in the completion cycle, garbage otherwise.
   int          rsp_mode = 0;
   logic [31:0] mem_model [0:1023];
   int          rcnt = 0;
   logic [9:0]  raddr = '0;
   logic        rrd = 1'b0;
   bit          hit;

   always @(negedge clk) begin
      hit = 1'b0;
      if (!rst_n) begin
         rcnt = 0;
      end else if (bus.mem_wr_en || bus.mem_rd_en) begin
         rcnt  = 2;
         raddr = bus.mem_addr;
         rrd   = bus.mem_rd_en;
         if (bus.mem_wr_en) mem_model[bus.mem_addr] = bus.mem_wr_data;
      end else if (rcnt != 0) begin
         rcnt--;
         hit = (rcnt == 0);
      end
      bus.mem_rd_data = (hit && rrd) ? mem_model[raddr] : 32'hBAD0_BAD0;
      case (rsp_mode)
         0:       bus.mem_ready = hit;
         1:       bus.mem_ready = 1'b1;
         default: bus.mem_ready = 1'b0;
      endcase
   end

   typedef struct {
      logic        wr;
      logic [9:0]  addr;
      logic [31:0] wdata;
      int          mode;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_cyc;
      int          hold;
   } vec_t;

   vec_t vecs [8];

   task automatic wait_ready(input string name);
      int n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(name, 96'(bus.req_ready), 96'(1));
   endtask

   task automatic run_txn(input vec_t v, input string tag);
      int   cyc;
      int   wr_p = 0, rd_p = 0, overlap = 0, addr_bad = 0, rr_bad = 0, stab_bad = 0;
      logic [95:0] snap;
      rsp_mode = v.mode;
      bus.rsp_ready = 1'b0;
      wait_ready({tag, "_ready"});
      bus.req_valid = 1'b1;
      bus.req_write = v.wr;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_addr  = ~v.addr;
      bus.req_wdata = ~v.wdata;
      cyc = 1;
      while (!bus.rsp_valid && cyc < 60) begin
         if (bus.mem_wr_en) wr_p++;
         if (bus.mem_rd_en) rd_p++;
         if (bus.mem_wr_en && bus.mem_rd_en) overlap++;
         if (bus.mem_addr != v.addr || (v.wr && bus.mem_wr_data != v.wdata)) addr_bad++;
         if (bus.req_ready) rr_bad++;
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_rsp_seen"}, 96'(bus.rsp_valid), 96'(1));
      chk({tag, "_latency"}, 96'(cyc), 96'(v.exp_cyc));
      chk({tag, "_wr_pulses"}, 96'(wr_p), 96'(v.wr ? 1 : 0));
      chk({tag, "_rd_pulses"}, 96'(rd_p), 96'(v.wr ? 0 : 1));
      chk({tag, "_no_overlap"}, 96'(overlap), 96'(0));
      chk({tag, "_addr_stable"}, 96'(addr_bad), 96'(0));
      chk({tag, "_req_ready_low"}, 96'(rr_bad), 96'(0));
      chk({tag, "_rdata"}, 96'(bus.rsp_rdata), 96'(v.exp_rdata));
      chk({tag, "_error"}, 96'(bus.rsp_error), 96'(v.exp_err));
      chk({tag, "_write"}, 96'(bus.rsp_write), 96'(v.wr));
      if (v.hold > 0) begin
         snap = 96'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_write, bus.rsp_error, bus.req_ready});
         for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            if (96'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_write, bus.rsp_error, bus.req_ready}) != snap)
               stab_bad++;
         end
         chk({tag, "_hold_stable"}, 96'(stab_bad), 96'(0));
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_back_to_idle"}, 96'({bus.rsp_valid, bus.req_ready}), 96'(2'b01));
      bus.rsp_ready = 1'b0;
   endtask

   logic        b2b_wr   [4];
   logic [9:0]  b2b_addr [4];
   logic [31:0] b2b_wd   [4];
   logic [31:0] b2b_rd   [4];

   initial begin
      vecs[0] = '{wr:1'b1, addr:10'h005, wdata:32'hDEADBEEF, mode:0, exp_rdata:32'h0,        exp_err:1'b0, exp_cyc:4,  hold:0};
      vecs[1] = '{wr:1'b0, addr:10'h005, wdata:32'h0,        mode:0, exp_rdata:32'hDEADBEEF, exp_err:1'b0, exp_cyc:4,  hold:0};
      vecs[2] = '{wr:1'b1, addr:10'h3FF, wdata:32'h12345678, mode:0, exp_rdata:32'h0,        exp_err:1'b0, exp_cyc:4,  hold:0};
      vecs[3] = '{wr:1'b0, addr:10'h3FF, wdata:32'h0,        mode:1, exp_rdata:32'h12345678, exp_err:1'b0, exp_cyc:4,  hold:0};
      vecs[4] = '{wr:1'b0, addr:10'h010, wdata:32'h0,        mode:2, exp_rdata:32'h0,        exp_err:1'b1, exp_cyc:18, hold:0};
      vecs[5] = '{wr:1'b1, addr:10'h020, wdata:32'hA5A55A5A, mode:0, exp_rdata:32'h0,        exp_err:1'b0, exp_cyc:4,  hold:10};
      vecs[6] = '{wr:1'b0, addr:10'h020, wdata:32'h0,        mode:0, exp_rdata:32'hA5A55A5A, exp_err:1'b0, exp_cyc:4,  hold:10};
      vecs[7] = '{wr:1'b1, addr:10'h001, wdata:32'hCAFEF00D, mode:0, exp_rdata:32'h0,        exp_err:1'b0, exp_cyc:4,  hold:0};

      b2b_wr   = '{1'b1, 1'b0, 1'b1, 1'b0};
      b2b_addr = '{10'h100, 10'h100, 10'h101, 10'h101};
      b2b_wd   = '{32'h11111111, 32'h0, 32'h22222222, 32'h0};
      b2b_rd   = '{32'h0, 32'h11111111, 32'h0, 32'h22222222};

      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs(), 96'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 96'(bus.req_ready), 96'(1));

      for (int i = 0; i < 8; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset while a write sits in WAIT
      begin
         int pulses = 0;
         rsp_mode = 2;
         wait_ready("rstmid_ready");
         bus.req_valid = 1'b1;
         bus.req_write = 1'b1;
         bus.req_addr  = 10'h040;
         bus.req_wdata = 32'h33333333;
         @(negedge clk);
         bus.req_valid = 1'b0;
         repeat (3) @(negedge clk);
         rst_n = 1'b0;
         #1;
         chk("rstmid_outputs", outs(), 96'(0));
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         chk("rstmid_ready_after", 96'(bus.req_ready), 96'(1));
         repeat (3) begin
            if (bus.rsp_valid || bus.mem_wr_en || bus.mem_rd_en) pulses++;
            @(negedge clk);
         end
         chk("rstmid_no_response", 96'(pulses), 96'(0));
         run_txn('{wr:1'b0, addr:10'h001, wdata:32'h0, mode:0, exp_rdata:32'hCAFEF00D,
                   exp_err:1'b0, exp_cyc:4, hold:0}, "post_rst");
      end

      // Back-to-back: req_valid held high across four requests
      begin
         int  idx = 0, nrsp = 0, pulses = 0, bad = 0, cyc = 0;
         bit  acc, inflight = 1'b0;
         rsp_mode = 0;
         bus.rsp_ready = 1'b1;
         wait_ready("b2b_ready");
         bus.req_valid = 1'b1;
         bus.req_write = b2b_wr[0];
         bus.req_addr  = b2b_addr[0];
         bus.req_wdata = b2b_wd[0];
         acc = bus.req_valid && bus.req_ready;
         while (nrsp < 4 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (acc) begin
               idx++;
               if (idx < 4) begin
                  bus.req_write = b2b_wr[idx];
                  bus.req_addr  = b2b_addr[idx];
                  bus.req_wdata = b2b_wd[idx];
               end else begin
                  bus.req_valid = 1'b0;
               end
            end
            if (bus.mem_wr_en && bus.mem_rd_en) bad++;
            if (bus.mem_wr_en || bus.mem_rd_en) begin
               if (inflight) bad++;
               inflight = 1'b1;
               pulses++;
            end
            if (bus.rsp_valid) begin
               chk($sformatf("b2b_rdata%0d", nrsp), 96'(bus.rsp_rdata), 96'(b2b_rd[nrsp]));
               chk($sformatf("b2b_write%0d", nrsp), 96'(bus.rsp_write), 96'(b2b_wr[nrsp]));
               nrsp++;
               inflight = 1'b0;
            end
            acc = bus.req_valid && bus.req_ready;
            if (acc && inflight) bad++;
         end
         chk("b2b_responses", 96'(nrsp), 96'(4));
         chk("b2b_pulses", 96'(pulses), 96'(4));
         chk("b2b_protocol", 96'(bad), 96'(0));
         bus.req_valid = 1'b0;
         bus.rsp_ready = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_req_initiator.md
Name: mem_req_initiator

Overview:
- Initiator side of the single-port memory command interface (wr_en/rd_en/addr/wr_data in, rd_data/ready out).
- Accepts one request at a time from a client over a valid/ready handshake and issues a one-cycle command pulse to the memory responder.
- Waits a minimum latency, then qualifies completion with mem_ready, and returns read data or a timeout error on a valid/ready response channel.
- Sits between bus-side client logic and the memory block.

Parameters:
- DATA_WIDTH, 32, width of write/read data.
- ADDR_WIDTH, 10, width of memory address.
- RSP_LATENCY, 2, cycles after the issue cycle before mem_ready is first sampled; legal range is 1 or more.
- TIMEOUT_CYCLES, 16, WAIT cycles after which the access is aborted with an error; must be greater than RSP_LATENCY.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  client request valid
- req_ready  output  1  initiator can accept a request
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  request address
- req_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  response valid
- rsp_ready  input  1  client accepts the response
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors
- rsp_write  output  1  echo of req_write
- rsp_error  output  1  access timed out
- mem_wr_en  output  1  write command pulse
- mem_rd_en  output  1  read command pulse
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wr_data  output  DATA_WIDTH  memory write data
- mem_rd_data  input  DATA_WIDTH  memory read data
- mem_ready  input  1  memory completion indication; may remain high between accesses

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs and internal registers are 0, state is IDLE, and req_ready is 0 during reset.
- Registered outputs: every output is registered, with no combinational input-to-output paths.

State machine (IDLE, ISSUE, WAIT, RESP):
- IDLE:
  - req_ready = 1.
  - If req_valid is high at a clock edge, capture req_write, req_addr and req_wdata, drop req_ready, and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_wr_en = write, mem_rd_en = !write. Only one of the two is ever high.
  - mem_addr and mem_wr_data are driven from the captured values.
  - Clear the wait counter, then go to WAIT.
- WAIT:
  - mem_wr_en and mem_rd_en are 0.
  - mem_addr and mem_wr_data are held stable for the whole state.
  - The counter increments each cycle; it reads 1 in the first WAIT cycle.
  - mem_ready is ignored while the counter is below RSP_LATENCY.
  - If the counter is RSP_LATENCY or more and mem_ready = 1:
    - load rsp_rdata with mem_rd_data for a read, or with 0 for a write;
    - set rsp_error = 0 and go to RESP.
  - Else, if the counter equals TIMEOUT_CYCLES: set rsp_error = 1 and rsp_rdata = 0, then go to RESP.
- RESP:
  - rsp_valid = 1, with rsp_rdata, rsp_write and rsp_error held stable until rsp_ready.
  - On rsp_valid and rsp_ready: clear rsp_valid and go to IDLE.
- Latency with RSP_LATENCY=2 against a responder that completes 2 cycles after the pulse:
  - request accepted at edge T;
  - mem_*_en high in cycle T+1;
  - mem_ready sampled in cycle T+3;
  - rsp_valid high in cycle T+4.
- Throughput: at most one request in flight. The next request is accepted at the earliest in the cycle after the response handshake.
- Sticky mem_ready: a high level left over from the previous access never completes the current access early. The RSP_LATENCY gate guarantees this.
- Backpressure:
  - req_valid dropping before acceptance has no effect.
  - rsp_ready low holds RESP indefinitely; the timeout does not apply in RESP.
- Reset mid-operation: the in-flight access is abandoned, no response is produced, mem_*_en drops immediately and the state returns to IDLE.
- Counter width: $clog2(TIMEOUT_CYCLES+1); the counter saturates and never wraps.

Decomposition:
- Shared package mem_req_pkg:
  - state enum typedef (IDLE, ISSUE, WAIT, RESP);
  - op typedef (OP_READ, OP_WRITE).
- Natural sub-module: mem_req_wait_timer.
  - Inputs: clear and enable.
  - Outputs: lat_met (counter ≥ RSP_LATENCY) and timed_out (counter == TIMEOUT_CYCLES).
  - Parameterised by RSP_LATENCY and TIMEOUT_CYCLES.

Test Plan:
- Write then read: write addr 0x005, data 0xDEADBEEF, with a 2-cycle responder model, then read addr 0x005. Required response: write gives rsp_valid with rsp_write=1, rsp_error=0, rsp_rdata=0; read gives rsp_rdata=0xDEADBEEF. mem_wr_en and mem_rd_en are each high for exactly 1 cycle, and mem_addr is stable at 0x005 through WAIT.
- Sticky mem_ready: hold mem_ready=1 permanently and issue a read of 0x3FF whose memory returns 0x12345678 on the correct cycle. Required response: completion is not before the RSP_LATENCY cycle, and rsp_rdata=0x12345678.
- Timeout: hold mem_ready=0 and issue a read of 0x010. Required response: rsp_valid asserts after 16 WAIT cycles with rsp_error=1 and rsp_rdata=0.
- Response backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid. Required response: outputs stay stable, req_ready stays 0, no timeout occurs, and IDLE is re-entered the cycle after rsp_ready=1.
- Reset mid-operation: assert rst_n=0 during WAIT of a write. Required response: all outputs are 0 immediately; after release, req_ready=1 and the next read of 0x001 completes normally.
- Back-to-back: present req_valid continuously for 4 requests. Required response: each is accepted only in IDLE, command pulses never overlap, and 4 responses arrive in order.
